mac_lane_accumulator: RTL and testbench

- Parametrised successor of the 8-lane neuron multiply-accumulator in the neural-network datapath. Sits between fetch_populate and rcal.
- Each beat carries LANES input/weight pairs. The block multiplies each pair, sums the lanes through a pipelined adder tree, and accumulates the sums across beats until the neuron's last beat.
- It then applies an arithmetic shift (optionally rounded) and saturates the result. It emits one W/F result per neuron to rcal.
- Backpressure is a true valid/ready handshake on both sides, replacing the old grant-only stall.

---
 rtl/mac_lane_accumulator.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mac_lane_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_accumulator.sv
// Neuron multiply-accumulator: per-beat lane products, pipelined adder tree,
// cross-beat accumulation, optional rounded shift, saturation and W/F split.
module mac_lane_accumulator #(
    parameter int          LANES      = 8,
    parameter int          IW         = 24,
    parameter int          WW         = 16,
    parameter int          ACCW       = 48,
    parameter int          OUTW       = 32,
    parameter int          FRACW      = 24,
    parameter int          MUL_LAT    = 3,
    parameter logic [31:0] SAT_LIM    = 32'h07FFFFFE,
    parameter int          TBL_STRIDE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IW-1:0]   in_data,
    input  logic [LANES*WW-1:0]   in_weight,
    input  logic                  in_last,
    input  logic [4:0]            in_neuronshift,
    input  logic [16:0]           in_neurontable,
    input  logic                  in_round_en,
    input  logic [4:0]            in_postshift,
    input  logic [16:0]           in_outputloc,
    input  logic                  in_done_layer,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUTW-1:0]       out_w,
    output logic [OUTW-1:0]       out_f,
    output logic [4:0]            out_postshift,
    output logic [16:0]           out_outputloc,
    output logic                  out_done_layer
);
    localparam int LVL = $clog2(LANES);
    localparam int PW  = IW + WW;
    localparam int DEP = MUL_LAT + LVL;
    localparam logic signed [ACCW:0] LIM_P    = (ACCW+1)'(SAT_LIM);
    localparam logic signed [ACCW:0] LIM_N    = -LIM_P;
    localparam logic [OUTW-1:0]      STRIDE_W = OUTW'(TBL_STRIDE);

    typedef struct packed {
        logic [16:0] tbl;
        logic [4:0]  ps;
        logic [16:0] oloc;
        logic        dn;
    } side_t;

    typedef struct packed {
        logic       last;
        logic [4:0] sh;
        logic       rnd;
        side_t      side;
    } beat_sb_t;

    logic                   stall_s;
    logic                   in_fire_s;
    beat_sb_t               in_sb_d;
    logic                   in_v_q;
    beat_sb_t               in_sb_q;
    logic [LANES*IW-1:0]    in_data_q;
    logic [LANES*WW-1:0]    in_weight_q;
    logic signed [PW-1:0]   prod_s [LANES];
    logic signed [PW-1:0]   prod_q [MUL_LAT][LANES];
    logic                   dv_q   [DEP];
    beat_sb_t               dsb_q  [DEP];
    logic signed [ACCW-1:0] node_q     [1:LANES-1];
    logic signed [ACCW-1:0] node_all_s [1:2*LANES-1];
    logic                   tv_s;
    beat_sb_t               tsb_s;
    logic signed [ACCW-1:0] acc_q;
    logic                   first_q;
    logic                   acc_v_q;
    logic                   acc_rnd_q;
    logic [4:0]             acc_sh_q;
    side_t                  acc_side_q;
    logic signed [ACCW:0]   acc_x_s;
    logic signed [ACCW:0]   rnd_s;
    logic signed [ACCW:0]   shf_d;
    logic signed [ACCW:0]   shf_q;
    logic                   shf_v_q;
    side_t                  shf_side_q;
    logic [OUTW-1:0]        sat_d;
    logic [OUTW-1:0]        sat_q;
    logic                   sat_v_q;
    side_t                  sat_side_q;
    logic signed [OUTW-1:0] int_x_s;
    logic [OUTW-1:0]        w_d;
    logic [OUTW-1:0]        f_d;
    logic                   out_valid_q;
    logic [OUTW-1:0]        out_w_q;
    logic [OUTW-1:0]        out_f_q;
    logic [4:0]             out_ps_q;
    logic [16:0]            out_oloc_q;
    logic                   out_dn_q;

    // A held result freezes the whole pipe, multipliers included.
    assign stall_s   = out_valid_q && !out_ready;
    assign in_ready  = !stall_s && !reset;
    assign in_fire_s = in_valid && in_ready;
    assign in_sb_d   = {in_last, in_neuronshift, in_round_en, in_neurontable,
                        in_postshift, in_outputloc, in_done_layer};

    // Input capture stage
    always_ff @(posedge clk) begin
        if (reset) begin
            in_v_q      <= 1'b0;
            in_sb_q     <= '0;
            in_data_q   <= '0;
            in_weight_q <= '0;
        end else if (!stall_s) begin
            in_v_q      <= in_fire_s;
            in_sb_q     <= in_sb_d;
            in_data_q   <= in_data;
            in_weight_q <= in_weight;
        end
    end

    // Per-lane signed products
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_s[k] = PW'($signed(in_data_q[k*IW +: IW])) * PW'($signed(in_weight_q[k*WW +: WW]));
        end
    end

    // Multiplier pipeline plus matching valid/sideband delay line through the tree
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                for (int k = 0; k < LANES; k++) begin
                    prod_q[s][k] <= '0;
                end
            end
            for (int s = 0; s < DEP; s++) begin
                dv_q[s]  <= 1'b0;
                dsb_q[s] <= '0;
            end
        end else if (!stall_s) begin
            prod_q[0] <= prod_s;
            for (int s = 1; s < MUL_LAT; s++) begin
                prod_q[s] <= prod_q[s-1];
            end
            dv_q[0]  <= in_v_q;
            dsb_q[0] <= in_sb_q;
            for (int s = 1; s < DEP; s++) begin
                dv_q[s]  <= dv_q[s-1];
                dsb_q[s] <= dsb_q[s-1];
            end
        end
    end

    // Heap-ordered tree: node i sums nodes 2i and 2i+1; leaves are the final products.
    always_comb begin
        for (int i = 1; i < LANES; i++) begin
            node_all_s[i] = node_q[i];
        end
        for (int k = 0; k < LANES; k++) begin
            node_all_s[LANES+k] = ACCW'(prod_q[MUL_LAT-1][k]);
        end
    end

    // Adder tree registers, one level per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < LANES; i++) begin
                node_q[i] <= '0;
            end
        end else if (!stall_s) begin
            for (int i = 1; i < LANES; i++) begin
                node_q[i] <= node_all_s[2*i] + node_all_s[2*i+1];
            end
        end
    end

    assign tv_s  = dv_q[DEP-1];
    assign tsb_s = dsb_q[DEP-1];

    // Cross-beat accumulator; only the last beat of a neuron travels on
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= '0;
            first_q    <= 1'b1;
            acc_v_q    <= 1'b0;
            acc_rnd_q  <= 1'b0;
            acc_sh_q   <= 5'd0;
            acc_side_q <= '0;
        end else if (!stall_s) begin
            acc_v_q    <= tv_s && tsb_s.last;
            acc_sh_q   <= tsb_s.sh;
            acc_rnd_q  <= tsb_s.rnd;
            acc_side_q <= tsb_s.side;
            if (tv_s) begin
                acc_q   <= (first_q ? {ACCW{1'b0}} : acc_q) + node_all_s[1];
                first_q <= tsb_s.last;
            end
        end
    end

    // One extra bit keeps the rounding add from wrapping.
    always_comb begin
        acc_x_s = {acc_q[ACCW-1], acc_q};
        rnd_s   = '0;
        if (acc_rnd_q && (acc_sh_q != 5'd0)) begin
            rnd_s = (ACCW+1)'(1'b1) << (acc_sh_q - 5'd1);
        end else begin
            rnd_s = '0;
        end
        shf_d = (acc_x_s + rnd_s) >>> acc_sh_q;
    end

    // Symmetric clamp then truncation
    always_comb begin
        sat_d = '0;
        if (shf_q > LIM_P) begin
            sat_d = LIM_P[OUTW-1:0];
        end else if (shf_q < LIM_N) begin
            sat_d = LIM_N[OUTW-1:0];
        end else begin
            sat_d = shf_q[OUTW-1:0];
        end
    end

    // Signed integer field indexes the activation table; fraction is zero-extended.
    always_comb begin
        int_x_s = OUTW'($signed(sat_q[OUTW-1:FRACW]));
        w_d     = int_x_s * STRIDE_W + {{(OUTW-17){1'b0}}, sat_side_q.tbl};
        f_d     = {{(OUTW-FRACW){1'b0}}, sat_q[FRACW-1:0]};
    end

    // Shift, saturate and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shf_q       <= '0;
            shf_v_q     <= 1'b0;
            shf_side_q  <= '0;
            sat_q       <= '0;
            sat_v_q     <= 1'b0;
            sat_side_q  <= '0;
            out_valid_q <= 1'b0;
            out_w_q     <= '0;
            out_f_q     <= '0;
            out_ps_q    <= 5'd0;
            out_oloc_q  <= 17'd0;
            out_dn_q    <= 1'b0;
        end else if (!stall_s) begin
            shf_q       <= shf_d;
            shf_v_q     <= acc_v_q;
            shf_side_q  <= acc_side_q;
            sat_q       <= sat_d;
            sat_v_q     <= shf_v_q;
            sat_side_q  <= shf_side_q;
            out_valid_q <= sat_v_q;
            out_w_q     <= w_d;
            out_f_q     <= f_d;
            out_ps_q    <= sat_side_q.ps;
            out_oloc_q  <= sat_side_q.oloc;
            out_dn_q    <= sat_side_q.dn;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_w          = out_w_q;
    assign out_f          = out_f_q;
    assign out_postshift  = out_ps_q;
    assign out_outputloc  = out_oloc_q;
    assign out_done_layer = out_dn_q;

endmodule

// File: tb/tb_mac_lane_accumulator.sv
// Scoreboard bench for mac_lane_accumulator: a behavioural model queues the
// expected result of every accepted last beat; a negedge monitor compares.
module tb_mac_lane_accumulator;
    localparam int     LANES   = 8;
    localparam int     IW      = 24;
    localparam int     WW      = 16;
    localparam int     OUTW    = 32;
    localparam longint SAT_LIM = 64'sh07FFFFFE;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*IW-1:0] in_data;
    logic [LANES*WW-1:0] in_weight;
    logic                in_last;
    logic [4:0]          in_neuronshift;
    logic [16:0]         in_neurontable;
    logic                in_round_en;
    logic [4:0]          in_postshift;
    logic [16:0]         in_outputloc;
    logic                in_done_layer;
    logic                out_valid;
    logic                out_ready;
    logic [OUTW-1:0]     out_w;
    logic [OUTW-1:0]     out_f;
    logic [4:0]          out_postshift;
    logic [16:0]         out_outputloc;
    logic                out_done_layer;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] f;
        logic [4:0]  ps;
        logic [16:0] oloc;
        logic        dn;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    int     outs   = 0;
    longint m_acc;
    bit     m_first;

    always #5 clk = ~clk;

    mac_lane_accumulator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
        .in_neuronshift(in_neuronshift), .in_neurontable(in_neurontable),
        .in_round_en(in_round_en), .in_postshift(in_postshift),
        .in_outputloc(in_outputloc), .in_done_layer(in_done_layer),
        .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_f(out_f),
        .out_postshift(out_postshift), .out_outputloc(out_outputloc),
        .out_done_layer(out_done_layer)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input longint acc, input int sh, input bit rnd,
                                   input logic [16:0] tbl, input logic [4:0] ps,
                                   input logic [16:0] oloc, input bit dn);
        longint             v;
        logic [31:0]        s;
        logic signed [31:0] ip;
        exp_t               e;
        v = acc;
        if (rnd && sh != 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > SAT_LIM) v = SAT_LIM;
        else if (v < -SAT_LIM) v = -SAT_LIM;
        s      = v[31:0];
        ip     = $signed(s[31:24]);
        e.w    = 32'(ip * 32'sd3) + {15'd0, tbl};
        e.f    = {8'd0, s[23:0]};
        e.ps   = ps;
        e.oloc = oloc;
        e.dn   = dn;
        return e;
    endfunction

    function automatic logic [LANES*IW-1:0] data_v(input logic [IW-1:0] v, input bit all);
        logic [LANES*IW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) if (all || k == 0) r[k*IW +: IW] = v;
        return r;
    endfunction

    function automatic logic [LANES*WW-1:0] wgt_v(input logic [WW-1:0] v, input bit all);
        logic [LANES*WW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) if (all || k == 0) r[k*WW +: WW] = v;
        return r;
    endfunction

    task automatic send_beat(input logic [LANES*IW-1:0] d, input logic [LANES*WW-1:0] w,
                             input bit last, input logic [4:0] sh, input logic [16:0] tbl,
                             input bit rnd, input logic [4:0] ps, input logic [16:0] oloc,
                             input bit dn);
        longint bs;
        int     n;
        in_valid = 1'b1; in_data = d; in_weight = w; in_last = last;
        in_neuronshift = sh; in_neurontable = tbl; in_round_en = rnd;
        in_postshift = ps; in_outputloc = oloc; in_done_layer = dn;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        end else begin
            bs = 0;
            for (int k = 0; k < LANES; k++)
                bs += longint'($signed(d[k*IW +: IW])) * longint'($signed(w[k*WW +: WW]));
            m_acc   = (m_first ? 64'sd0 : m_acc) + bs;
            m_first = last;
            if (last) sb_q.push_back(model(m_acc, int'(sh), rnd, tbl, ps, oloc, dn));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every presented result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                check_eq("out_w", 64'(out_w), 64'(sb_q[0].w));
                check_eq("out_f", 64'(out_f), 64'(sb_q[0].f));
                check_eq("out_postshift", 64'(out_postshift), 64'(sb_q[0].ps));
                check_eq("out_outputloc", 64'(out_outputloc), 64'(sb_q[0].oloc));
                check_eq("out_done_layer", 64'(out_done_layer), 64'(sb_q[0].dn));
                if (!out_ready) begin
                    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
                end else begin
                    void'(sb_q.pop_front());
                    outs++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        int n;
        int outs0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_weight = '0; in_last = 1'b0;
        in_neuronshift = 5'd0; in_neurontable = 17'd0; in_round_en = 1'b0;
        in_postshift = 5'd0; in_outputloc = 17'd0; in_done_layer = 1'b0;
        out_ready = 1'b1; m_acc = 0; m_first = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_w", 64'(out_w), 64'd0);
        check_eq("rst_out_f", 64'(out_f), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: all lanes 1*2, latency measured counting the accepting edge as edge 1
        send_beat(data_v(24'd1, 1'b1), wgt_v(16'd2, 1'b1), 1'b1, 5'd0, 17'd5, 1'b0, 5'd1, 17'd10, 1'b0);
        idle();
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check_eq("latency", 64'(lat), 64'd11);
        drain("t1_drain");

        // 2: three-beat neurons, positive then negative weight, back to back
        for (int b = 0; b < 3; b++)
            send_beat(data_v(24'd100, 1'b0), wgt_v(16'd3, 1'b0), b == 2, 5'd2, 17'd7, 1'b0, 5'd2, 17'd20, 1'b0);
        for (int b = 0; b < 3; b++)
            send_beat(data_v(24'd100, 1'b0), wgt_v(16'hFFFD, 1'b0), b == 2, 5'd2, 17'd9, 1'b0, 5'd3, 17'd21, 1'b1);
        idle();
        drain("t2_drain");

        // 3: rounding, single-beat neurons every cycle
        send_beat(data_v(24'd5, 1'b0), wgt_v(16'd1, 1'b0), 1'b1, 5'd1, 17'd0, 1'b0, 5'd4, 17'd30, 1'b0);
        send_beat(data_v(24'd5, 1'b0), wgt_v(16'd1, 1'b0), 1'b1, 5'd1, 17'd0, 1'b1, 5'd5, 17'd31, 1'b0);
        send_beat(data_v(24'hFFFFFB, 1'b0), wgt_v(16'd1, 1'b0), 1'b1, 5'd1, 17'd4, 1'b1, 5'd6, 17'd32, 1'b1);
        idle();
        drain("t3_drain");

        // 4: positive and negative saturation
        for (int b = 0; b < 4; b++)
            send_beat(data_v(24'h7FFFFF, 1'b1), wgt_v(16'h7FFF, 1'b1), b == 3, 5'd0, 17'd0, 1'b0, 5'd7, 17'd40, 1'b0);
        for (int b = 0; b < 4; b++)
            send_beat(data_v(24'h7FFFFF, 1'b1), wgt_v(16'h8001, 1'b1), b == 3, 5'd0, 17'd0, 1'b0, 5'd8, 17'd41, 1'b1);
        idle();
        drain("t4_drain");

        // 5: backpressure held for 6 cycles once the first result appears
        out_ready = 1'b0;
        send_beat(data_v(24'd1, 1'b1), wgt_v(16'd2, 1'b1), 1'b1, 5'd0, 17'd1, 1'b0, 5'd3, 17'd100, 1'b0);
        send_beat(data_v(24'd2, 1'b1), wgt_v(16'd3, 1'b1), 1'b1, 5'd1, 17'd2, 1'b0, 5'd7, 17'd200, 1'b1);
        idle();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_valid_rise", 64'(out_valid), 64'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("t5_drain");

        // 6: reset in the middle of a four-beat neuron
        outs0 = outs;
        for (int b = 0; b < 2; b++)
            send_beat(data_v(24'd1000, 1'b1), wgt_v(16'd7, 1'b1), 1'b0, 5'd0, 17'd0, 1'b0, 5'd0, 17'd0, 1'b0);
        idle();
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_first = 1'b1;
        m_acc   = 0;
        send_beat(data_v(24'd1, 1'b1), wgt_v(16'd2, 1'b1), 1'b1, 5'd0, 17'd3, 1'b0, 5'd9, 17'd300, 1'b1);
        idle();
        drain("t6_drain");
        repeat (20) @(negedge clk);
        check_eq("t6_out_count", 64'(outs - outs0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
